// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional fault reporting is enabled by defining IFETCH_FAULT_EN.
package ifetch_pkg;

  localparam int PC_WIDTH_DEF   = 32;
  localparam int INSTR_WIDTH    = 32;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int unsigned PC_INC = 4;

  typedef logic [$clog2(FIFO_DEPTH_DEF)-1:0]   fifo_ptr_t;
  typedef logic [$clog2(FIFO_DEPTH_DEF+1)-1:0] fifo_cnt_t;

  // One buffered instruction as seen by decode.
  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0] pc;
    logic [INSTR_WIDTH-1:0]  instr;
`ifdef IFETCH_FAULT_EN
    logic                    fault;
`endif
  } fetch_entry_t;

  // True when the PC has any bit set above the instruction memory's byte range.
  function automatic logic pc_out_of_range(input logic [63:0] pc, input int unsigned addr_bits);
    return (pc >> (addr_bits + 2)) != 64'd0;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count, used as the
// fetch-to-decode buffer. Push while full is accepted only with a pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop, do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointer and count bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, drives the split X/Y memory address, captures the
// one-cycle-latency read data and buffers {instr, pc} for decode.
// Define IFETCH_FAULT_EN to add InstrFault and bad-target/overrun faulting.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int                  ADDR_BITS  = 8,
  parameter int                  DATA_WIDTH = INSTR_WIDTH,
  parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Redirect,
  input  logic [PC_WIDTH-1:0]    RedirectPC,
  output logic [ADDR_BITS/2-1:0] X_addr,
  output logic [ADDR_BITS/2-1:0] Y_addr,
  input  logic [DATA_WIDTH-1:0]  MemData,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  output logic [DATA_WIDTH-1:0]  InstrData,
`ifdef IFETCH_FAULT_EN
  output logic [PC_WIDTH-1:0]    InstrPC,
  output logic                   InstrFault
`else
  output logic [PC_WIDTH-1:0]    InstrPC
`endif
);

`ifdef IFETCH_FAULT_EN
  localparam int FW = 1;
`else
  localparam int FW = 0;
`endif
  localparam int EW = PC_WIDTH + DATA_WIDTH + FW;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [PC_WIDTH-1:0]  fetch_pc_q, inflight_pc_q;
  logic                 inflight_q;
  logic [ADDR_BITS-1:0] word;
  logic [CW-1:0]        count;
  logic [OW-1:0]        occupancy;
  logic                 pop, push, issue_ok, issue;
  logic [EW-1:0]        wdata, rdata;

  assign word   = fetch_pc_q[ADDR_BITS+1:2];
  assign X_addr = word[ADDR_BITS-1:ADDR_BITS/2];
  assign Y_addr = word[ADDR_BITS/2-1:0];

  assign pop       = InstrValid && InstrReady;
  // Buffered + in-flight entries after this cycle's pop must leave a free slot.
  assign occupancy = OW'(count) + OW'(inflight_q) - OW'(pop);
  assign issue_ok  = !Redirect && (occupancy < OW'(FIFO_DEPTH));
  // A redirect kills whatever read is returning this cycle.
  assign push      = inflight_q && !Redirect;

`ifdef IFETCH_FAULT_EN
  logic fault_q, inflight_fault_q, redirect_bad, seq_bad, seq_fault;
  assign redirect_bad = (RedirectPC[1:0] != 2'b00) ||
                        pc_out_of_range(64'(RedirectPC), ADDR_BITS);
  assign seq_bad   = pc_out_of_range(64'(fetch_pc_q), ADDR_BITS);
  assign issue     = issue_ok && !fault_q && !seq_bad;
  assign seq_fault = issue_ok && !fault_q && seq_bad;
  assign wdata     = {inflight_pc_q, inflight_fault_q ? '0 : MemData, inflight_fault_q};
`else
  assign issue = issue_ok;
  assign wdata = {inflight_pc_q, MemData};
`endif

  // PC, in-flight slot and fault state; a fault entry reuses the in-flight slot.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
`ifdef IFETCH_FAULT_EN
      fault_q          <= 1'b0;
      inflight_fault_q <= 1'b0;
`endif
    end else if (Redirect) begin
      fetch_pc_q <= RedirectPC & ~PC_WIDTH'(3);
      inflight_q <= 1'b0;
`ifdef IFETCH_FAULT_EN
      fault_q          <= redirect_bad;
      inflight_fault_q <= redirect_bad;
      if (redirect_bad) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= RedirectPC;
      end
`endif
    end else if (issue) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= fetch_pc_q;
      fetch_pc_q    <= fetch_pc_q + PC_WIDTH'(PC_INC);
`ifdef IFETCH_FAULT_EN
      inflight_fault_q <= 1'b0;
`endif
    end
`ifdef IFETCH_FAULT_EN
    else if (seq_fault) begin
      fault_q          <= 1'b1;
      inflight_q       <= 1'b1;
      inflight_fault_q <= 1'b1;
      inflight_pc_q    <= fetch_pc_q;
    end
`endif
    else begin
      inflight_q <= 1'b0;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .flush_i (Redirect),
    .rdata_o (rdata),
    .count_o (count)
  );

  assign InstrValid = (count != '0);
  assign InstrPC    = InstrValid ? rdata[EW-1 -: PC_WIDTH] : '0;
  assign InstrData  = InstrValid ? rdata[DATA_WIDTH+FW-1 -: DATA_WIDTH] : '0;
`ifdef IFETCH_FAULT_EN
  assign InstrFault = InstrValid && rdata[0];
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run scored against a stream model (consecutive PCs from the
// last redirect target). Builds with or without IFETCH_FAULT_EN.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int AB = 8;

  logic        Clock = 1'b0, Reset_n = 1'b0, Redirect = 1'b0, InstrReady = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic [3:0]  X_addr, Y_addr, wX, wY;
  logic [31:0] MemData, wMemData, InstrData, InstrPC, wData, wPC;
  logic        InstrValid, wValid;
`ifdef IFETCH_FAULT_EN
  logic        InstrFault, wFault;
`endif
  logic [31:0] mem [256];
  int checks = 0, failures = 0;

  always #5 Clock = ~Clock;

  // Instruction memory: registered read, one cycle latency.
  always @(posedge Clock) begin
    MemData  <= mem[{X_addr, Y_addr}];
    wMemData <= mem[{wX, wY}];
  end

  instruction_fetch #(.ADDR_BITS(AB), .DATA_WIDTH(32), .PC_WIDTH(32),
                      .RESET_PC(32'h0000_0010), .FIFO_DEPTH(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .X_addr(X_addr), .Y_addr(Y_addr), .MemData(MemData), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .InstrData(InstrData),
`ifdef IFETCH_FAULT_EN
    .InstrFault(InstrFault),
`endif
    .InstrPC(InstrPC));

  instruction_fetch #(.ADDR_BITS(AB), .DATA_WIDTH(32), .PC_WIDTH(32),
                      .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_w (
    .Clock(Clock), .Reset_n(Reset_n), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .X_addr(wX), .Y_addr(wY), .MemData(wMemData), .InstrValid(wValid),
    .InstrReady(InstrReady), .InstrData(wData),
`ifdef IFETCH_FAULT_EN
    .InstrFault(wFault),
`endif
    .InstrPC(wPC));

  // ---- reference model helpers (stream semantics) ----
  function automatic logic bad_pc(input logic [31:0] pc);
`ifdef IFETCH_FAULT_EN
    return (pc[1:0] != 2'b00) || (pc >= 32'h0000_0400);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] pc);
    return bad_pc(pc) ? 32'h0 : mem[pc[AB+1:2]];
  endfunction

  function automatic logic [31:0] target_pc(input logic [31:0] t);
`ifdef IFETCH_FAULT_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic next_cycle();
    @(negedge Clock); #1;
  endtask

  task automatic start(input logic rdy);
    Redirect = 1'b0; InstrReady = rdy; Reset_n = 1'b0;
    @(negedge Clock); @(negedge Clock);
    Reset_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    logic [31:0] p;
    InstrReady = 1'b1; Redirect = 1'b0; Reset_n = 1'b0;
    @(negedge Clock); #1;
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", InstrValid); end
    checks++; if (InstrData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", InstrData); end
    checks++; if (InstrPC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", InstrPC); end
    Reset_n = 1'b1; #1;
    checks++; if ({X_addr, Y_addr} !== 8'h04) begin failures++; $display("FAIL reset_addr got=%h/%h exp=0/4", X_addr, Y_addr); end
    checks++; if ({wX, wY} !== 8'hFF) begin failures++; $display("FAIL wrap_addr got=%h/%h exp=f/f", wX, wY); end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c < 2) begin
        checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL latency_early c=%0d got=%b exp=0", c, InstrValid); end
      end else begin
        p = 32'h10 + 32'(4 * (c - 2));
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== p || InstrData !== mem[p[AB+1:2]]) begin
          failures++; $display("FAIL reset_seq c=%0d got=%b/%h/%h exp=1/%h/%h", c, InstrValid, InstrPC, InstrData, p, mem[p[AB+1:2]]);
        end
      end
`ifdef IFETCH_FAULT_EN
      if (c == 2) begin
        checks++; if (wValid !== 1'b1 || wFault !== 1'b1 || wPC !== 32'hFFFF_FFFC || wData !== 32'h0) begin
          failures++; $display("FAIL overrun_fault got=%b/%b/%h/%h exp=1/1/fffffffc/0", wValid, wFault, wPC, wData); end
      end
      if (c == 3) begin
        checks++; if (wValid !== 1'b0) begin failures++; $display("FAIL overrun_halt got=%b exp=0", wValid); end
      end
`else
      if (c == 2) begin
        checks++; if (wValid !== 1'b1 || wPC !== 32'hFFFF_FFFC || wData !== mem[255]) begin
          failures++; $display("FAIL wrap_first got=%b/%h/%h exp=1/fffffffc/%h", wValid, wPC, wData, mem[255]); end
      end
      if (c == 3) begin
        checks++; if (wValid !== 1'b1 || wPC !== 32'h0 || wData !== mem[0]) begin
          failures++; $display("FAIL wrap_zero got=%b/%h/%h exp=1/0/%h", wValid, wPC, wData, mem[0]); end
      end
`endif
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    start(1'b0);
    repeat (6) next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h10) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/10", InstrValid, InstrPC); end
    checks++; if ({X_addr, Y_addr} !== 8'h06) begin failures++; $display("FAIL stall_pc_frozen got=%h/%h exp=0/6", X_addr, Y_addr); end
    InstrReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      p = 32'h10 + 32'(4 * k);
      checks++;
      if (InstrValid !== 1'b1 || InstrPC !== p || InstrData !== mem[p[AB+1:2]]) begin
        failures++; $display("FAIL stall_release k=%0d got=%b/%h/%h exp=1/%h/%h", k, InstrValid, InstrPC, InstrData, p, mem[p[AB+1:2]]);
      end
    end
  endtask

  task automatic test_redirect();
    start(1'b0);
    repeat (2) next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h10) begin failures++; $display("FAIL redir_pre got=%b/%h exp=1/10", InstrValid, InstrPC); end
    Redirect = 1'b1; RedirectPC = 32'h40; InstrReady = 1'b1;
    next_cycle(); Redirect = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", InstrValid); end
    next_cycle();
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", InstrValid); end
    next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h40 || InstrData !== mem[16]) begin
      failures++; $display("FAIL redir_target got=%b/%h/%h exp=1/40/%h", InstrValid, InstrPC, InstrData, mem[16]); end
    next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h44) begin failures++; $display("FAIL redir_next got=%b/%h exp=1/44", InstrValid, InstrPC); end
  endtask

  task automatic test_back_to_back();
    start(1'b1);
    repeat (4) next_cycle();
    Redirect = 1'b1; RedirectPC = 32'h40;
    next_cycle(); RedirectPC = 32'h80;
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL b2b_flush1 got=%b exp=0", InstrValid); end
    next_cycle(); Redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL b2b_bubble k=%0d got=%b/%h exp=0", k, InstrValid, InstrPC); end
      next_cycle();
    end
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h80 || InstrData !== mem[32]) begin
      failures++; $display("FAIL b2b_last_wins got=%b/%h/%h exp=1/80/%h", InstrValid, InstrPC, InstrData, mem[32]); end
    next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h84) begin failures++; $display("FAIL b2b_next got=%b/%h exp=1/84", InstrValid, InstrPC); end
  endtask

  task automatic test_async_reset();
    start(1'b1);
    repeat (4) next_cycle();
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", InstrValid); end
    @(posedge Clock); #2; Reset_n = 1'b0; #1;
    checks++; if (InstrValid !== 1'b0 || InstrPC !== 32'h0) begin failures++; $display("FAIL areset_immediate got=%b/%h exp=0/0", InstrValid, InstrPC); end
    checks++; if ({X_addr, Y_addr} !== 8'h04) begin failures++; $display("FAIL areset_addr got=%h/%h exp=0/4", X_addr, Y_addr); end
    @(negedge Clock); Reset_n = 1'b1; #1;
    next_cycle();
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL areset_restart_early got=%b exp=0", InstrValid); end
    next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h10) begin failures++; $display("FAIL areset_restart got=%b/%h exp=1/10", InstrValid, InstrPC); end
  endtask

`ifdef IFETCH_FAULT_EN
  task automatic test_fault();
    start(1'b1);
    repeat (4) next_cycle();
    Redirect = 1'b1; RedirectPC = 32'h42;
    next_cycle(); Redirect = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL fault_flush got=%b exp=0", InstrValid); end
    next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrFault !== 1'b1 || InstrPC !== 32'h42 || InstrData !== 32'h0) begin
      failures++; $display("FAIL fault_entry got=%b/%b/%h/%h exp=1/1/42/0", InstrValid, InstrFault, InstrPC, InstrData); end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL fault_halt k=%0d got=%b/%h exp=0", k, InstrValid, InstrPC); end
    end
    Redirect = 1'b1; RedirectPC = 32'h0;
    next_cycle(); Redirect = 1'b0;
    next_cycle(); next_cycle();
    checks++; if (InstrValid !== 1'b1 || InstrFault !== 1'b0 || InstrPC !== 32'h0 || InstrData !== mem[0]) begin
      failures++; $display("FAIL fault_resume got=%b/%b/%h/%h exp=1/0/0/%h", InstrValid, InstrFault, InstrPC, InstrData, mem[0]); end
  endtask
`endif

  function automatic logic [31:0] gen_target();
`ifdef IFETCH_FAULT_EN
    if ($urandom_range(0, 7) == 0) return $urandom();
    return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
`else
    return $urandom();
`endif
  endfunction

  task automatic test_random();
    logic [31:0] exp_pc = 32'h10;
    logic        halted = 1'b0, redir_bad = 1'b0;
    int          since_redir = 100, delivered = 0;
    start(1'b1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge Clock);
      InstrReady = ($urandom_range(0, 9) < 7);
      Redirect   = ($urandom_range(0, 19) == 0);
      if (Redirect) RedirectPC = gen_target();
      #1;
      if (since_redir < (redir_bad ? 1 : 2)) begin
        checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL rnd_bubble cyc=%0d got=%b/%h exp=0", cyc, InstrValid, InstrPC); end
      end
      if (halted) begin
        checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%b/%h exp=0", cyc, InstrValid, InstrPC); end
      end else if (InstrValid === 1'b1 && InstrReady) begin
        checks++;
        if (InstrPC !== exp_pc || InstrData !== exp_data(exp_pc)
`ifdef IFETCH_FAULT_EN
            || InstrFault !== bad_pc(exp_pc)
`endif
           ) begin
          failures++; $display("FAIL rnd_stream cyc=%0d got=%h/%h exp=%h/%h", cyc, InstrPC, InstrData, exp_pc, exp_data(exp_pc));
        end
        if (bad_pc(exp_pc)) halted = 1'b1;
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (Redirect) begin
        exp_pc = target_pc(RedirectPC); halted = 1'b0; since_redir = 0; redir_bad = bad_pc(exp_pc);
      end else begin
        since_redir++;
      end
    end
    Redirect = 1'b0;
    checks++; if (delivered < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_async_reset();
`ifdef IFETCH_FAULT_EN
    test_fault();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Holds the PC and drives the memory's split X/Y word address.
- Captures the memory's one-cycle-latency read data and buffers each instruction with its PC in a small FIFO.
- Presents instructions to decode over a valid/ready handshake; handles branch/jump redirects with in-flight kill and flush.

Parameters:
- ADDR_BITS, 8: instruction memory word-address bits. X = upper half, Y = lower half.
- DATA_WIDTH, 32: instruction width.
- PC_WIDTH, 32: program counter width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FIFO_DEPTH, 2: output buffer entries; must be ≥2.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Redirect  in  1  load RedirectPC and flush, this cycle.
- RedirectPC  in  PC_WIDTH  redirect target.
- X_addr  out  ADDR_BITS/2  memory row address.
- Y_addr  out  ADDR_BITS/2  memory column address.
- MemData  in  DATA_WIDTH  memory read data; valid one cycle after the address.
- InstrValid  out  1  FIFO head valid.
- InstrReady  in  1  decode accepts the head.
- InstrData  out  DATA_WIDTH  head instruction.
- InstrPC  out  PC_WIDTH  head PC.

Behaviour:
- Clock/reset: single clock Clock; Reset_n asynchronous assert, active-low; deassertion synchronized externally.
- Reset values: fetch_pc=RESET_PC, FIFO empty, in-flight flag 0. InstrValid=0, InstrData=0, InstrPC=0.
- Address: word = fetch_pc[ADDR_BITS+1:2]; X_addr = word[ADDR_BITS-1:ADDR_BITS/2], Y_addr = word[ADDR_BITS/2-1:0]. Driven combinationally from fetch_pc. PC bits above ADDR_BITS+1 are ignored (aliasing).
- pop = InstrValid & InstrReady.
- Issue condition in a cycle: not Redirect AND (count + inflight − pop) < FIFO_DEPTH.
  - On issue, the memory samples the address at the edge; inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - Otherwise fetch_pc holds. The address keeps showing fetch_pc; the re-read is harmless.
- Return: when inflight=1 and the slot was not killed, next cycle push {MemData, inflight_pc}. Latency is PC issue to InstrValid = 2 edges when the FIFO is empty.
- Throughput: one instruction per cycle sustained with FIFO_DEPTH=2 and InstrReady held 1.
- Push and pop in the same cycle are allowed at any count, including full with pop.
- Redirect in cycle t:
  - At the edge: fetch_pc<=RedirectPC with bits [1:0] forced to 0; FIFO count<=0; in-flight slot killed.
  - No issue in cycle t. The target is issued at t+1 and reaches decode at the earliest at t+3.
  - Redirect overrides any simultaneous pop; the popped head is still considered consumed by decode.
- Back-to-back redirects: the last one wins.
- PC wrap: fetch_pc+4 wraps modulo 2^PC_WIDTH.
- Reset mid-operation: everything returns to reset values immediately; in-flight data is discarded.
- Never drives memory write; MemData is X-tolerant only when the entry is killed.

Optional Feature:
IFETCH_FAULT_EN:
- Adds output InstrFault (1 bit, travels with each FIFO entry; reset 0).
- A redirect target with bits[1:0]≠0, or any bit set above ADDR_BITS+1, enters FAULT state:
  - pushes one entry with InstrFault=1, InstrData=0, InstrPC=raw target;
  - stops issuing until the next Redirect.
- Sequential wrap past the memory top also faults, at the first out-of-range PC.
- Without the macro: no port; low bits are silently cleared and upper bits alias.

Decomposition:
- Package ifetch_pkg: PC_WIDTH default, instruction width, PC increment constant, FIFO pointer/count typedefs, fetch_entry_t {pc, instr[, fault]}.
- Sub-module ifetch_fifo: parameterised synchronous FIFO with push/pop/flush and count output, reused for the buffer.

Test Plan:
- Reset with RESET_PC=0x10, InstrReady=1 → X_addr=0, Y_addr=4 on the first cycle; InstrPC sequence 0x10, 0x14, 0x18 on consecutive cycles from cycle 2.
- InstrReady=0 for 5 cycles → exactly 2 entries buffered, fetch_pc frozen at 0x18. Release → 0x10, 0x14, 0x18 in order, no duplicates or gaps.
- Redirect to 0x40 while full and in flight → head valid drops next cycle; the next delivered InstrPC is 0x40; 0x18 is never delivered.
- Redirect asserted 2 cycles in a row (0x40 then 0x80) → first delivered is 0x80.
- RESET_PC=0xFFFF_FFFC → next fetched PC is 0x0 (wrap); Reset_n pulsed mid-stream → InstrValid=0 asynchronously, restart at RESET_PC.
- IFETCH_FAULT_EN, Redirect to 0x42 → single entry InstrFault=1, InstrPC=0x42, no further issues; Redirect to 0x0 → normal fetch resumes.
